// File: rtl/board_state_scanner.sv
// Raster-order reader for the board state RAM: streams every cell over valid/ready and tallies stones.
// Optional SCAN_EMPTY_COUNT_EN adds an empty_count output tallying empty cells.
module board_state_scanner #(
    parameter int DATA_BITS      = 2,
    parameter int EDGE_ADDR_BITS = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [2*EDGE_ADDR_BITS-1:0] rd_addr,
    input  logic [DATA_BITS-1:0]        rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EDGE_ADDR_BITS-1:0]   out_x,
    output logic [EDGE_ADDR_BITS-1:0]   out_y,
    output logic [DATA_BITS-1:0]        out_data,
    output logic                        out_last,
    output logic [2*EDGE_ADDR_BITS:0]   black_count,
    output logic [2*EDGE_ADDR_BITS:0]   white_count
`ifdef SCAN_EMPTY_COUNT_EN
    ,
    output logic [2*EDGE_ADDR_BITS:0]   empty_count
`endif
);

    localparam int AW = 2 * EDGE_ADDR_BITS;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0]        MAX_IDX = '1;
    localparam logic [DATA_BITS-1:0] CELL_EMPTY = DATA_BITS'(0);
    localparam logic [DATA_BITS-1:0] CELL_BLACK = DATA_BITS'(1);
    localparam logic [DATA_BITS-1:0] CELL_WHITE = DATA_BITS'(2);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             index_q, index_d;
    logic                      exhausted_q, exhausted_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;
    logic [EDGE_ADDR_BITS-1:0] x_q, x_d, y_q, y_d;
    logic [DATA_BITS-1:0]      data_q, data_d;
    logic                      done_q, done_d;
    logic [CW-1:0]             black_q, black_d, white_q, white_d;
    logic [CW-1:0]             empty_q, empty_d;
    logic                      load, accept;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        exhausted_d = exhausted_q;
        valid_d     = valid_q;
        last_d      = last_q;
        x_d         = x_q;
        y_d         = y_q;
        data_d      = data_q;
        done_d      = 1'b0;
        black_d     = black_q;
        white_d     = white_q;
        empty_d     = empty_q;
        // exhausted_q stops the index at the last cell so nothing is re-read
        load   = (state_q == SCAN) && !exhausted_q && (!valid_q || out_ready);
        accept = valid_q && out_ready;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SCAN;
                    index_d     = '0;
                    exhausted_d = 1'b0;
                    black_d     = '0;
                    white_d     = '0;
                    empty_d     = '0;
                end
            end
            SCAN: begin
                if (accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        index_d = '0;
                    end
                end
                if (load) begin
                    data_d     = rd_data;
                    {y_d, x_d} = index_q;
                    valid_d    = 1'b1;
                    last_d     = (index_q == MAX_IDX);
                    if (index_q == MAX_IDX) exhausted_d = 1'b1;
                    else                    index_d     = index_q + 1'b1;
                    if (rd_data == CELL_BLACK) black_d = black_q + 1'b1;
                    if (rd_data == CELL_WHITE) white_d = white_q + 1'b1;
                    if (rd_data == CELL_EMPTY) empty_d = empty_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            index_q     <= '0;
            exhausted_q <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            black_q     <= '0;
            white_q     <= '0;
            empty_q     <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            exhausted_q <= exhausted_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            x_q         <= x_d;
            y_q         <= y_d;
            data_q      <= data_d;
            done_q      <= done_d;
            black_q     <= black_d;
            white_q     <= white_d;
            empty_q     <= empty_d;
        end
    end

    assign busy        = (state_q == SCAN);
    assign done        = done_q;
    assign rd_addr     = index_q;
    assign out_valid   = valid_q;
    assign out_x       = x_q;
    assign out_y       = y_q;
    assign out_data    = data_q;
    assign out_last    = last_q;
    assign black_count = black_q;
    assign white_count = white_q;
`ifdef SCAN_EMPTY_COUNT_EN
    assign empty_count = empty_q;
`else
    logic unused_empty;
    assign unused_empty = ^empty_q;
`endif

endmodule

// File: doc/board_state_scanner.md
Name: board_state_scanner

Overview:
- Reader-side companion to the checkerboard state RAM.
- On `start`, walks every cell in raster order (y outer, x inner) through the RAM's combinational read port.
- Streams each cell out over a valid/ready interface (display/UART/scoring consumers) and accumulates black/white stone counts.
- Sits between the board RAM read port and downstream consumers; the RAM write port remains owned by game logic.

Parameters:
- DATA_BITS, 2, width of one cell state (0 = empty, 1 = black, 2 = white, 3 = reserved).
- EDGE_ADDR_BITS, 3, bits per coordinate; board is 2^EDGE_ADDR_BITS square (8x8 default).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse when the final beat is accepted.
- rd_addr  out  2*EDGE_ADDR_BITS  RAM read address, {y, x}, y in upper bits.
- rd_data  in  DATA_BITS  RAM combinational read data for rd_addr.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat when out_valid & out_ready.
- out_x  out  EDGE_ADDR_BITS  column of beat.
- out_y  out  EDGE_ADDR_BITS  row of beat.
- out_data  out  DATA_BITS  cell state of beat.
- out_last  out  1  high on beat for address 2^(2*EDGE_ADDR_BITS)-1.
- black_count  out  2*EDGE_ADDR_BITS+1  number of cells == 1 loaded this scan.
- white_count  out  2*EDGE_ADDR_BITS+1  number of cells == 2 loaded this scan.

Behaviour:
- Reset (rst high at edge): state = IDLE; index = 0; all outputs 0; counts 0. Applies mid-scan; any pending beat is dropped.
- FSM states and transitions:
  - IDLE -> SCAN on `start`. Index cleared and counts cleared on that same edge.
  - SCAN -> IDLE when the beat with out_last is accepted. `done` pulses high in the cycle after that edge.
- `start` while busy is ignored. `start` held high across done re-launches a scan in the next IDLE cycle.
- rd_addr = index in every state; it equals 0 in IDLE.
- Output register (single stage):
  - Load condition: in SCAN, index not yet exhausted, and (out_valid == 0 or out_ready == 1).
  - On load: out_data <= rd_data; {out_y, out_x} <= index; out_valid <= 1; out_last <= (index == max); index++.
- Latency:
  - `start` sampled at edge N -> first beat (0,0) is valid after edge N+1.
  - With out_ready held high, one beat per cycle; 64 beats occupy edges N+1..N+64.
  - out_valid falls after final acceptance if nothing is loaded.
- Backpressure: while out_valid & !out_ready, out_* and index hold stable; no RAM re-read.
- Counts:
  - Increment on load when rd_data == 1 (black) or 2 (white); values 0 and 3 are not counted.
  - Width holds the full-board value (64) without wrap.
  - Held after done until the next `start` or rst.
- Concurrent RAM writes: each cell is sampled at its load cycle. No snapshot guarantee; a write to an unread cell is visible, a write to an already-read cell is not.
- Index stops at max; no wrap or re-read after the last load.

Optional Feature:
- Macro: SCAN_EMPTY_COUNT_EN.
- Defined: adds output `empty_count` (2*EDGE_ADDR_BITS+1 bits), incrementing on loads with rd_data == 0, with the same reset/clear/hold rules as the other counts.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- All-empty RAM, start, out_ready=1 -> 64 beats on consecutive cycles in raster order; out_last only on (7,7); done pulses one cycle after; black=white=0 (empty_count=64 if enabled).
- Black at (x=3,y=5), white at (0,0), rest empty -> beat 0 data 2, beat 43 data 1; black=1, white=1.
- out_ready toggling 1,0,0,1,... on alternating-stone board -> no beat lost/duplicated; out_* stable during stall; black=32, white=32; done only after the 64th acceptance.
- Pulse `start` at beat 10 of a scan -> ignored; scan completes 64 beats with one done.
- rst asserted at beat 20 -> next cycle out_valid=0, busy=0, counts=0, rd_addr=0; subsequent start scans from (0,0).
- Write cell 63 = 1 during a scan at beat 30 -> beat 63 reports 1; write cell 0 = 2 at beat 30 -> beat 0 keeps old value.
